rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
//  Examples of that resource: a measurement counter or a priority-encoded datapath.
//  It picks one requester, holds a registered one-hot grant until release, then rotates priority.
//  It sits between the requester bank and the shared unit's select/enable inputs.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2, need not be power of two)
//  log2N     2   width of grant index, ceil(log2(NUM_REQ))
//  MAX_HOLD  16  max grant length in cycles (used only with RR_TIMEOUT_EN), >=2
// PORTS
//  clk       in   1        single clock, all state on rising edge
//  rst       in   1        asynchronous, active-high reset
//  req       in   NUM_REQ  request vector, level, bit i = requester i
//  done      in   1        1-cycle pulse from shared resource: current job finished
//  gnt       out  NUM_REQ  registered one-hot grant (all-zero when none)
//  gnt_idx   out  log2N    binary index of granted requester, valid when gnt_vld
//  gnt_vld   out  1        high while any grant is active
//  timeout   out  1        1-cycle pulse: last grant was force-released (RR_TIMEOUT_EN only)
// BEHAVIOUR
//  - Reset (async, immediate): gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, state=IDLE.
//  - ptr = highest-priority index; winner = first set req bit scanning ptr, ptr+1 .. wrapping mod NUM_REQ.
//  - States:
//    - IDLE: if |req, grant winner at next edge -> GRANT; else stay. Latency req->gnt = 1 cycle.
//    - GRANT: gnt/gnt_idx frozen. Release conditions, checked each cycle:
//      - done==1, or req[gnt_idx]==0, or (RR_TIMEOUT_EN) hold_cnt==MAX_HOLD-1.
//      - On release edge: gnt=0, gnt_vld=0, ptr=(gnt_idx+1) mod NUM_REQ, -> RELEASE.
//    - RELEASE: exactly one dead cycle with gnt=0. If |req, grant winner (new ptr) at next edge
//      -> GRANT; else -> IDLE.
//  - Back-to-back grants are separated by exactly one zero-grant cycle.
//  - done outside GRANT is ignored; req changes during GRANT do not change gnt_idx.
//  - gnt never has more than one bit set; gnt_idx is consistent with gnt every cycle.
//  - Simultaneous done and hold limit: treated as normal release, timeout stays 0.
//  - ptr wrap: gnt_idx==NUM_REQ-1 gives ptr=0; non-power-of-two NUM_REQ never yields
//    ptr>=NUM_REQ.
//  - Reset during GRANT: gnt drops asynchronously, ptr returns to 0; no timeout pulse.
// CONFIGURATION
//  RR_TIMEOUT_EN defined:
//    - log2(MAX_HOLD)-bit hold_cnt, cleared on entering GRANT, +1 per GRANT cycle.
//    - A grant lasting MAX_HOLD cycles is force-released.
//    - timeout=1 during the following RELEASE cycle.
//  RR_TIMEOUT_EN undefined:
//    - No counter; grant held until done or request drop.
//    - timeout tied 0; MAX_HOLD ignored.
// STRUCTURE
//  Shared package rr_arb_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2
//    - function idx2onehot.
//  Sub-module rr_pick (combinational): inputs req, ptr; outputs win_idx, win_vld.
//    - Masked double-scan: first set bit >= ptr, else first set bit from 0.
//  rr_arbiter holds FSM, ptr, output registers, optional hold counter.
// TESTING (NUM_REQ=4, MAX_HOLD=16)
//  1. After reset, req=4'b0100 -> next edge gnt=4'b0100, gnt_idx=2, gnt_vld=1.
//  2. req=4'b1111 held, done pulsed 2 cycles after each grant
//     -> gnt_idx sequence 0,1,2,3,0, one zero-grant cycle between each.
//  3. Grant on idx 3, done, req=4'b1001 -> ptr=0, next gnt=4'b0001 (wrap).
//  4. Grant on idx 1, req[1] drops -> gnt=0 next edge, RELEASE, then idx 2 granted if req[2]=1.
//  5. RR_TIMEOUT_EN, req=4'b0001 held, no done -> gnt high 16 cycles, timeout=1 for 1 cycle,
//     gnt=4'b0001 re-granted after the gap. Without the macro: gnt stays high, timeout=0.
//  6. rst=1 mid-GRANT -> gnt=0, gnt_vld=0 before next edge.
//     After rst release with req=4'b1111 -> gnt_idx=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state encoding and one-hot helper for rr_arbiter
package rr_arb_pkg;

    // Widest requester bank the one-hot helper can express
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Binary index to one-hot; callers narrow the result to their bank width
    function automatic logic [MAX_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select (masked double scan)
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int log2N   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [log2N-1:0]   ptr,
    output logic [log2N-1:0]   win_idx,
    output logic               win_vld
);

    logic [NUM_REQ-1:0] masked;
    logic [log2N-1:0]   hi_idx;
    logic [log2N-1:0]   lo_idx;

    // Keep only requests at or above ptr so the first scan honours rotation
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (log2N'(i) >= ptr);
        end
    end

    // Lowest set bit of the masked and unmasked vectors; scanning downward lets the lowest hit win
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) hi_idx = log2N'(i);
            if (req[i])    lo_idx = log2N'(i);
        end
    end

    // Wrap to the unmasked scan only when nothing at or above ptr is requesting
    assign win_vld = |req;
    assign win_idx = (|masked) ? hi_idx : lo_idx;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant; RR_TIMEOUT_EN adds hold limit
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int log2N    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [log2N-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam logic [log2N-1:0] LAST_IDX = log2N'(NUM_REQ - 1);

    state_t             state;
    logic [log2N-1:0]   ptr;
    logic [log2N-1:0]   win_idx;
    logic               win_vld;
    logic [NUM_REQ-1:0] win_onehot;
    logic [log2N-1:0]   next_ptr;
    logic               hold_hit;
    logic               release_now;
    logic               forced;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .log2N   (log2N)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign win_onehot = NUM_REQ'(idx2onehot(IDX_W'(win_idx)));

    // Explicit wrap keeps ptr inside 0..NUM_REQ-1 for non-power-of-two banks
    assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

`ifdef RR_TIMEOUT_EN
    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Count grant cycles; any non-GRANT cycle clears it so each grant starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == ST_GRANT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    assign hold_hit = (state == ST_GRANT) && (hold_cnt == HOLD_LAST);
`else
    assign hold_hit = 1'b0;
`endif

    assign release_now = done || !req[gnt_idx] || hold_hit;
    // A hold-limit release only counts as a timeout when nothing else would have released it
    assign forced      = hold_hit && !done && req[gnt_idx];

    // Grant FSM with registered grant, index, valid and timeout outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (win_vld) begin
                        gnt     <= win_onehot;
                        gnt_idx <= win_idx;
                        gnt_vld <= 1'b1;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= next_ptr;
                        timeout <= forced;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    timeout <= 1'b0;
                    if (win_vld) begin
                        gnt     <= win_onehot;
                        gnt_idx <= win_idx;
                        gnt_vld <= 1'b1;
                        state   <= ST_GRANT;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    gnt     <= '0;
                    gnt_vld <= 1'b0;
                    timeout <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter against a behavioural model
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_vld;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 granted, 2 dead cycle after a release
    int   m_phase;
    int   m_owner;
    int   m_ptr;
    int   m_len;
    logic m_to;

    rr_arbiter #(
        .NUM_REQ  (N),
        .log2N    (2),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_phase == 1) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_len   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        bit hit;
        m_to = 1'b0;
        if (m_phase == 1) begin
            hit = TO_EN && (m_len == MAX_HOLD);
            if (d || !r[m_owner] || hit) begin
                m_to    = hit && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_phase = 2;
            end else begin
                m_len++;
            end
        end else if (r != '0) begin
            m_owner = m_pick(r, m_ptr);
            m_len   = 1;
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", gnt_vld); end
        checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst = 1'b0;
        req = '0;
        model_reset();
    endtask

    task automatic test_first_grant();
        do_reset();
        tick(4'b0100, 1'b0);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL first_gnt got=%b exp=%b", gnt, 4'b0100); end
        checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL first_idx got=%0d exp=2", gnt_idx); end
        checks++; if (gnt_vld !== 1'b1) begin errors++; $display("FAIL first_vld got=%b exp=1", gnt_vld); end
    endtask

    task automatic test_rotation();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            tick(4'b1111, 1'b0);
            checks++;
            if (gnt_vld !== 1'b1 || gnt_idx !== 2'(exp_seq[n])) begin
                errors++; $display("FAIL rotation_idx step=%0d got vld=%b idx=%0d exp vld=1 idx=%0d", n, gnt_vld, gnt_idx, exp_seq[n]);
            end
            tick(4'b1111, 1'b0);
            checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rotation_hold step=%0d got=%b exp=%b", n, gnt, m_gnt()); end
            tick(4'b1111, 1'b1);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rotation_gap step=%0d got=%b exp=0000", n, gnt); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(4'b1000, 1'b0);
        checks++; if (gnt_idx !== 2'd3) begin errors++; $display("FAIL wrap_first got=%0d exp=3", gnt_idx); end
        tick(4'b1001, 1'b1);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wrap_gap got=%b exp=0000", gnt); end
        tick(4'b1001, 1'b0);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_next got=%b exp=0001", gnt); end
    endtask

    task automatic test_req_drop();
        do_reset();
        tick(4'b0010, 1'b0);
        checks++; if (gnt_idx !== 2'd1) begin errors++; $display("FAIL drop_first got=%0d exp=1", gnt_idx); end
        tick(4'b0100, 1'b0);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release got=%b exp=0000", gnt); end
        tick(4'b0100, 1'b0);
        checks++; if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin errors++; $display("FAIL drop_next got=%b/%0d exp=0100/2", gnt, gnt_idx); end
    endtask

    task automatic test_hold_limit();
        do_reset();
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick(4'b0001, 1'b0);
            checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL hold_high cyc=%0d got gnt=%b to=%b exp gnt=0001 to=0", c, gnt, timeout); end
        end
`ifdef RR_TIMEOUT_EN
        tick(4'b0001, 1'b0);
        checks++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("FAIL hold_timeout got gnt=%b to=%b exp gnt=0000 to=1", gnt, timeout); end
        tick(4'b0001, 1'b0);
        checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL hold_regrant got gnt=%b to=%b exp gnt=0001 to=0", gnt, timeout); end
`else
        for (int c = 0; c < 4; c++) begin
            tick(4'b0001, 1'b0);
            checks++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL hold_no_limit cyc=%0d got gnt=%b to=%b exp gnt=0001 to=0", c, gnt, timeout); end
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b1);
        tick(4'b1111, 1'b0);
        checks++; if (gnt_idx !== 2'd1 || gnt_vld !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0d/%b exp=1/1", gnt_idx, gnt_vld); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin errors++; $display("FAIL areset_drop got gnt=%b vld=%b exp 0000/0", gnt, gnt_vld); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL areset_timeout got=%b exp=0", timeout); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick(4'b1111, 1'b0);
        checks++; if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin errors++; $display("FAIL areset_after got=%b/%0d exp=0001/0", gnt, gnt_idx); end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         d;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            d = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0 && m_phase == 1) r[m_owner] = 1'b1;
            tick(r, d);
            checks++;
            if (gnt !== m_gnt() || gnt_vld !== (m_phase == 1) || timeout !== m_to) begin
                errors++; $display("FAIL random_out cyc=%0d got gnt=%b vld=%b to=%b exp gnt=%b vld=%b to=%b", c, gnt, gnt_vld, timeout, m_gnt(), (m_phase == 1), m_to);
            end
            if (m_phase == 1) begin
                checks++;
                if (gnt_idx !== 2'(m_owner)) begin errors++; $display("FAIL random_idx cyc=%0d got=%0d exp=%0d", c, gnt_idx, m_owner); end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        test_reset();
        test_first_grant();
        test_rotation();
        test_wrap();
        test_req_drop();
        test_hold_limit();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
